// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send, then
// clocks out one command byte on device-generated clock edges and checks the ACK.
`timescale 1ns/1ps

module ps2_host_tx #(
    parameter int unsigned INHIBIT_CYCLES = 10_000,
    parameter int unsigned TIMEOUT_CYCLES = 1_500_000,
    parameter int unsigned SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       rx_inhibit,
    output logic       tx_done,
    output logic       tx_nack,
    output logic       tx_timeout
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                         : TIMEOUT_CYCLES;
    localparam int unsigned CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        ACK,
        WAIT_IDLE
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] data_sync;
    logic                   clk_prev;
    logic                   clk_s;
    logic                   data_s;
    logic                   clk_fall;
    logic                   stalled;
    logic                   accept;
    logic                   idle_next;
    logic [CW-1:0]          cnt;
    logic [8:0]             frame;
    logic [3:0]             bit_cnt;

    assign clk_s     = clk_sync[SYNC_STAGES-1];
    assign data_s    = data_sync[SYNC_STAGES-1];
    assign clk_fall  = clk_prev & ~clk_s;
    assign stalled   = (cnt == TO_LAST) & ~clk_fall;
    assign accept    = tx_valid & tx_ready;
    assign idle_next = (state == IDLE) & ~accept;

    // Idle bus is high, so the chains reset to 1 to avoid a phantom falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '1;
            data_sync <= '1;
            clk_prev  <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_in};
            data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data_in};
            clk_prev  <= clk_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            rx_inhibit  <= 1'b0;
            tx_done     <= 1'b0;
            tx_nack     <= 1'b0;
            tx_timeout  <= 1'b0;
            cnt         <= '0;
            frame       <= '0;
            bit_cnt     <= '0;
        end else begin
            tx_done    <= 1'b0;
            tx_nack    <= 1'b0;
            tx_timeout <= 1'b0;
            // Handshake flags follow the registered state, so tx_ready rises the
            // cycle after a completion pulse rather than alongside it.
            tx_ready   <= idle_next;
            busy       <= ~idle_next;
            rx_inhibit <= ~idle_next;

            case (state)
                IDLE: begin
                    if (accept) begin
                        frame       <= {~^tx_data, tx_data};
                        bit_cnt     <= '0;
                        cnt         <= '0;
                        ps2_clk_oe  <= 1'b1;
                        ps2_data_oe <= 1'b0;
                        state       <= INHIBIT;
                    end
                end

                INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        cnt         <= '0;
                        ps2_data_oe <= 1'b1;
                        state       <= RTS;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                RTS: begin
                    ps2_clk_oe <= 1'b0;
                    state      <= SEND;
                end

                SEND, ACK, WAIT_IDLE: begin
                    cnt <= clk_fall ? '0 : cnt + CNT_ONE;
                    if (stalled) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        tx_timeout  <= 1'b1;
                        state       <= IDLE;
                    end else if (state == SEND && clk_fall) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd9) begin
                            ps2_data_oe <= 1'b0;
                            state       <= ACK;
                        end else begin
                            ps2_data_oe <= ~frame[0];
                            frame       <= {1'b0, frame[8:1]};
                        end
                    end else if (state == ACK && clk_fall) begin
                        if (data_s) begin
                            tx_nack <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            state <= WAIT_IDLE;
                        end
                    end else if (state == WAIT_IDLE && clk_s && data_s) begin
                        tx_done <= 1'b1;
                        state   <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: table of command bytes against a PS/2 device model,
// plus hand-written sequences for timeout, mid-frame reset and back-to-back requests.
`timescale 1ns/1ps

module tb_ps2_host_tx;

    localparam int INH = 20;
    localparam int TO  = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, rx_inhibit;
    logic       tx_done, tx_nack, tx_timeout;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_in, ps2_data_in;
    logic [9:0] cap;
    bit         dev_started;
    int         checks = 0;
    int         failures = 0;

    // Open-drain wired-AND of host and device.
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    always #5 clk = ~clk;

    ps2_host_tx #(
        .INHIBIT_CYCLES(INH),
        .TIMEOUT_CYCLES(TO),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .ps2_clk_in(ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe),
        .busy(busy),
        .rx_inhibit(rx_inhibit),
        .tx_done(tx_done),
        .tx_nack(tx_nack),
        .tx_timeout(tx_timeout)
    );

    typedef struct {
        logic [7:0] data;
        bit         ack;
        int         hold;
        int         exp_par;
        int         exp_done;
        int         exp_nack;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Device: waits for request-to-send, then 40-cycle clocks, sampling on rising edge.
    task automatic device(input int nclk, input bit ack, input int hold);
        int waited = 0;
        dev_started = 0;
        cap = '0;
        while (!(ps2_clk_in && !ps2_data_in) && waited < 200) begin
            tick(1);
            waited++;
        end
        if (ps2_clk_in && !ps2_data_in) dev_started = 1;
        if (dev_started) begin
            tick(10);
            for (int k = 1; k <= nclk; k++) begin
                dev_clk = 1'b0;
                tick(20);
                dev_clk = 1'b1;
                if (k <= 10) cap[k-1] = ps2_data_in;
                if (k == 10 && ack) begin
                    tick(5);
                    dev_data = 1'b0;
                    tick(15);
                end else if (k == 11) begin
                    tick(hold);
                    dev_data = 1'b1;
                end else begin
                    tick(20);
                end
            end
        end
        dev_clk  = 1'b1;
        dev_data = 1'b1;
    endtask

    task automatic inhibit_phase();
        int n = 0;
        while (ps2_clk_oe && !ps2_data_oe && n < 100) begin
            n++;
            tick(1);
        end
        chk("inhibit_len", n, INH);
        chk("rts_oe", {ps2_clk_oe, ps2_data_oe}, 3);
        tick(1);
        chk("release_oe", {ps2_clk_oe, ps2_data_oe}, 1);
    endtask

    task automatic begin_xfer(input logic [7:0] d);
        chk("ready_before", tx_ready, 1);
        tx_data  = d;
        tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        inhibit_phase();
    endtask

    task automatic wait_pulse(input int budget, output int nd, output int nn,
                              output int nt, output int bad_hs, output int rel);
        int cyc = 0;
        nd = 0; nn = 0; nt = 0; bad_hs = 0; rel = 0;
        while (cyc < budget) begin
            tick(1);
            cyc++;
            if (tx_done || tx_nack || tx_timeout) begin
                nd  = int'(tx_done);
                nn  = int'(tx_nack);
                nt  = int'(tx_timeout);
                rel = int'(dev_data);
                break;
            end
            if (tx_ready || !busy || !rx_inhibit) bad_hs++;
        end
    endtask

    task automatic after_pulse(input string tag);
        chk({tag, "_ready_at_pulse"}, tx_ready, 0);
        tick(1);
        chk({tag, "_ready_after"}, tx_ready, 1);
        chk({tag, "_busy_after"}, {busy, rx_inhibit}, 0);
        chk({tag, "_oe_after"}, {ps2_clk_oe, ps2_data_oe}, 0);
    endtask

    task automatic quiet(input int n, output int pulses, output int oe_act);
        pulses = 0; oe_act = 0;
        repeat (n) begin
            tick(1);
            pulses += int'(tx_done) + int'(tx_nack) + int'(tx_timeout);
            oe_act += int'(ps2_clk_oe) + int'(ps2_data_oe) + int'(busy);
        end
    endtask

    task automatic do_row(input vec_t v, input string tag);
        int nd, nn, nt, bad, rel, pq, oq;
        fork
            device(11, v.ack, v.hold);
            begin
                begin_xfer(v.data);
                wait_pulse(1500, nd, nn, nt, bad, rel);
                after_pulse(tag);
            end
        join
        chk({tag, "_dev_started"}, int'(dev_started), 1);
        chk({tag, "_cap_data"}, int'(cap[7:0]), int'(v.data));
        chk({tag, "_cap_parity"}, int'(cap[8]), v.exp_par);
        chk({tag, "_cap_stop"}, int'(cap[9]), 1);
        chk({tag, "_done"}, nd, v.exp_done);
        chk({tag, "_nack"}, nn, v.exp_nack);
        chk({tag, "_timeout"}, nt, 0);
        chk({tag, "_handshake_busy"}, bad, 0);
        if (v.exp_done != 0) chk({tag, "_done_after_release"}, rel, 1);
        quiet(30, pq, oq);
        chk({tag, "_extra_pulses"}, pq, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no_finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nd, nn, nt, bad, rel, pq, oq, n;

        vecs[0] = '{data: 8'hF4, ack: 1'b1, hold: 5,   exp_par: 0, exp_done: 1, exp_nack: 0};
        vecs[1] = '{data: 8'hFF, ack: 1'b0, hold: 5,   exp_par: 1, exp_done: 0, exp_nack: 1};
        vecs[2] = '{data: 8'h00, ack: 1'b1, hold: 5,   exp_par: 1, exp_done: 1, exp_nack: 0};
        vecs[3] = '{data: 8'hA5, ack: 1'b1, hold: 5,   exp_par: 1, exp_done: 1, exp_nack: 0};
        vecs[4] = '{data: 8'h37, ack: 1'b1, hold: 100, exp_par: 0, exp_done: 1, exp_nack: 0};
        vecs[5] = '{data: 8'h80, ack: 1'b1, hold: 5,   exp_par: 0, exp_done: 1, exp_nack: 0};

        // Reset state
        tick(3);
        chk("rst_ready", tx_ready, 1);
        chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("rst_busy", {busy, rx_inhibit}, 0);
        chk("rst_pulses", {tx_done, tx_nack, tx_timeout}, 0);
        rst = 1'b0;
        tick(2);
        chk("post_rst_ready", tx_ready, 1);

        for (int i = 0; i < 6; i++) begin
            do_row(vecs[i], $sformatf("row%0d", i));
        end

        // Device never clocks: timeout 200 cycles after clock release
        begin_xfer(8'h5A);
        n = 0;
        nd = 0; nn = 0;
        while (!tx_timeout && n < 400) begin
            tick(1);
            n++;
            nd += int'(tx_done);
            nn += int'(tx_nack);
        end
        chk("to_latency", n, TO);
        chk("to_oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("to_other_pulses", nd + nn, 0);
        after_pulse("to");

        // Reset mid-frame after the 4th device clock of 0xAA
        fork
            device(4, 1'b1, 5);
            begin_xfer(8'hAA);
        join
        chk("mid_cap_low_bits", int'(cap[3:0]), 4'hA);
        chk("mid_busy_before", busy, 1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("mid_rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        chk("mid_rst_busy", {busy, rx_inhibit}, 0);
        chk("mid_rst_ready", tx_ready, 1);
        chk("mid_rst_pulses", {tx_done, tx_nack, tx_timeout}, 0);
        quiet(300, pq, oq);
        chk("mid_quiet_pulses", pq, 0);
        chk("mid_quiet_active", oq, 0);
        do_row(vecs[0], "recover");

        // tx_valid held across two transfers, data changed mid-frame
        fork
            device(11, 1'b1, 5);
            begin
                chk("b2b_ready_before", tx_ready, 1);
                tx_data  = 8'h96;
                tx_valid = 1'b1;
                tick(1);
                inhibit_phase();
                tick(30);
                tx_data = 8'h3C;
                wait_pulse(1500, nd, nn, nt, bad, rel);
                chk("b2b1_done", nd, 1);
                chk("b2b1_handshake_busy", bad, 0);
                chk("b2b1_ready_at_pulse", tx_ready, 0);
            end
        join
        chk("b2b1_cap_data", int'(cap[7:0]), 8'h96);
        chk("b2b1_cap_parity", int'(cap[8]), 1);
        fork
            device(11, 1'b1, 5);
            begin
                tick(1);
                chk("b2b_ready_after_done", tx_ready, 1);
                tick(1);
                chk("b2b2_accepted", {busy, tx_ready, ps2_clk_oe}, 3'b101);
                inhibit_phase();
                tx_valid = 1'b0;
                wait_pulse(1500, nd, nn, nt, bad, rel);
                chk("b2b2_done", nd, 1);
                chk("b2b2_handshake_busy", bad, 0);
                after_pulse("b2b2");
            end
        join
        chk("b2b2_cap_data", int'(cap[7:0]), 8'h3C);
        chk("b2b2_cap_parity", int'(cap[8]), 1);
        quiet(30, pq, oq);
        chk("b2b_no_third", oq, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
